hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 4, register-address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16, maximum data-memory wait cycles before error.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports ifid_rs, ifid_rt  in  REG_ADDR_W  source registers of the instruction in ID.
REQ-007 SHALL have port idex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
REQ-008 SHALL have port idex_memread  in  1  EX instruction is a load.
REQ-009 SHALL have port branch_taken  in  1  branch resolved taken in EX.
REQ-010 SHALL have ports mem_req, mem_ack  in  1  MEM-stage access request and completion.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en, exmem_en  out  1  stage-register enables.
REQ-012 SHALL have ports ifid_flush, idex_bubble, memwb_bubble  out  1  squash controls.
REQ-013 SHALL have port mem_timeout  out  1  sticky watchdog error.
REQ-014 SHALL have port stall_cnt  out  CNT_W  stall-cycle count (macro-dependent).

Function
REQ-015 SHALL implement FSM states INIT, RUN, MEM_WAIT, ERR.
REQ-016 INIT SHALL drive all enables 0 and all squash outputs 0, then move to RUN on the next edge.
REQ-017 freeze = mem_req && !mem_ack in RUN or MEM_WAIT.
REQ-018 When freeze is active, the block SHALL drive all four enables 0 and memwb_bubble 1, and SHALL force ifid_flush and idex_bubble to 0.
REQ-019 RUN with freeze active SHALL go to MEM_WAIT and load the wait counter with 1.
REQ-020 MEM_WAIT SHALL increment the wait counter each cycle while freeze is active.
REQ-021 MEM_WAIT SHALL return to RUN on the edge after mem_ack=1.
REQ-022 mem_ack=1 in the cycle of mem_req (zero-wait) SHALL cause no freeze and no state change.
REQ-023 When the wait counter reaches MEM_TIMEOUT with freeze still active, the FSM SHALL enter ERR and set mem_timeout=1.
REQ-024 ERR SHALL drive all enables 0 and memwb_bubble 1, and SHALL hold until reset.
REQ-025 When not frozen, branch_taken=1 SHALL drive ifid_flush=1, idex_bubble=1 and all enables 1 in the same cycle.
REQ-026 When not frozen and not branching, a load-use hazard SHALL drive pc_en=0, ifid_en=0 and idex_bubble=1 for that cycle, with exmem_en=1 and idex_en=1.
REQ-027 A load-use hazard is idex_memread && idex_rd!=0 && (idex_rd==ifid_rs || idex_rd==ifid_rt).
REQ-028 Priority SHALL be ERR > freeze > branch > load-use > normal.
REQ-029 Normal operation SHALL drive all enables 1 and all squash outputs 0.
REQ-030 Outputs SHALL be combinational from state and inputs; state and counters SHALL be registered.

Reset
REQ-031 rst_n=0 SHALL immediately force state INIT, wait counter 0, mem_timeout 0 and stall_cnt 0.
REQ-032 Asserting reset during MEM_WAIT or ERR SHALL abandon the state; deassertion SHALL always pass through INIT for one cycle.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined, stall_cnt SHALL increment once per cycle in which pc_en=0 outside INIT, and SHALL saturate at all-ones.
REQ-034 With HAZARD_PERF_CNT_EN undefined, stall_cnt SHALL be constant 0 and the block SHALL contain no counter logic.

Verification
REQ-035 Load-use scenario: idex_memread=1, idex_rd=3, ifid_rs=3 -> pc_en=0, ifid_en=0, idex_bubble=1 for exactly 1 cycle.
REQ-036 Load to register 0: idex_memread=1, idex_rd=0, ifid_rt=0 -> no stall.
REQ-037 Memory wait: mem_req=1 with mem_ack low for 3 cycles, then high -> 3 frozen cycles, then RUN; stall_cnt=3 with the macro defined.
REQ-038 Simultaneous events: freeze active with branch_taken=1 -> ifid_flush=0 while frozen; ifid_flush=1 in the first unfrozen cycle while branch_taken is still held.
REQ-039 Timeout: MEM_TIMEOUT=4, mem_ack held 0 -> ERR after 4 wait cycles, mem_timeout=1, enables stay 0.
REQ-040 Reset in ERR: drop rst_n -> mem_timeout=0 immediately; after release, one INIT cycle with enables 0, then all enables 1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch squash, data-memory freeze with watchdog.
// Define HAZARD_PERF_CNT_EN to build the saturating stall-cycle counter behind stall_cnt.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  memwb_bubble,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERR} state_t;

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_mem_timeout;
  logic                w_freeze;
  logic                w_load_use;

  assign w_freeze   = (r_state == RUN || r_state == MEM_WAIT) && mem_req && !mem_ack;
  assign w_load_use = idex_memread && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs) || (idex_rd == ifid_rt));

  // State, wait counter and sticky watchdog flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= INIT;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        INIT: r_state <= RUN;
        RUN: begin
          if (w_freeze) begin
            if (MEM_TIMEOUT <= 1) begin
              r_state       <= ERR;
              r_mem_timeout <= 1'b1;
            end else begin
              r_state <= MEM_WAIT;
            end
            r_wait_cnt <= WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (w_freeze) begin
            // The increment that would reach MEM_TIMEOUT trips the watchdog instead
            if (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
              r_state       <= ERR;
              r_mem_timeout <= 1'b1;
            end
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end else begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end
        end
        default: r_state <= ERR;
      endcase
    end
  end

  assign mem_timeout = r_mem_timeout;

  // Stage enables and squash controls: ERR > freeze > branch > load-use > normal
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    case (r_state)
      INIT: ;
      ERR:  memwb_bubble = 1'b1;
      default: begin
        if (w_freeze) begin
          memwb_bubble = 1'b1;
        end else if (branch_taken) begin
          pc_en       = 1'b1;
          ifid_en     = 1'b1;
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (w_load_use) begin
          idex_en     = 1'b1;
          exmem_en    = 1'b1;
          idex_bubble = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
        end
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of cycles with the PC held, ignoring the post-reset INIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state != INIT && !pc_en && r_stall_cnt != '1) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_hazard_ctrl;

  localparam int unsigned AW  = 4;
  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] O_ZERO = 7'b0000000;
  localparam logic [6:0] O_FRZ  = 7'b0000001;
  localparam logic [6:0] O_BR   = 7'b1111110;
  localparam logic [6:0] O_LU   = 7'b0011010;
  localparam logic [6:0] O_NORM = 7'b1111000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ifid_rs = '0, ifid_rt = '0, idex_rd = '0;
  logic          idex_memread = 1'b0, branch_taken = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic          pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble;
  logic          mem_timeout;
  logic [CW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rd(idex_rd),
    .idex_memread(idex_memread), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wire [6:0] outs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_bubble, memwb_bubble};

  // Behavioural model: post-reset flag, error flag, run length of frozen cycles, stall tally
  bit          m_init = 1'b1;
  bit          m_err  = 1'b0;
  int          m_frz  = 0;
  logic [CW-1:0] m_stall = '0;
  logic [6:0]  m_e;

  function automatic logic [6:0] exp_out();
    bit frz, lu;
    frz = mem_req && !mem_ack;
    lu  = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt);
    if (m_init)            return O_ZERO;
    else if (m_err || frz) return O_FRZ;
    else if (branch_taken) return O_BR;
    else if (lu)           return O_LU;
    else                   return O_NORM;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_init  <= 1'b1;
      m_err   <= 1'b0;
      m_frz   <= 0;
      m_stall <= '0;
    end else if (m_init) begin
      m_init <= 1'b0;
    end else begin
      m_e = exp_out();
      if (!m_e[6] && m_stall != {CW{1'b1}}) m_stall <= m_stall + 1'b1;
      if (!m_err) begin
        if (mem_req && !mem_ack) begin
          if (m_frz + 1 >= int'(TO)) m_err <= 1'b1;
          m_frz <= m_frz + 1;
        end else begin
          m_frz <= 0;
        end
      end
    end
  end

  task automatic set_in(input logic [AW-1:0] rs, rt, rd,
                        input logic mr, br, rq, ak);
    @(negedge clk);
    ifid_rs = rs; ifid_rt = rt; idex_rd = rd;
    idex_memread = mr; branch_taken = br; mem_req = rq; mem_ack = ak;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifid_rs = '0; ifid_rt = '0; idex_rd = '0;
    idex_memread = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    branch_taken = 1'b1;
    #1;
    checks++;
    if ({outs, mem_timeout, stall_cnt} !== {O_ZERO, 1'b0, CW'(0)}) begin
      errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, {outs, mem_timeout, stall_cnt}, {O_ZERO, 1'b0, CW'(0)});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (outs !== O_ZERO) begin
      errors++; $display("FAIL reset_init cyc=%0d got=%b exp=%b", cyc, outs, O_ZERO);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (outs !== O_NORM) begin
      errors++; $display("FAIL reset_run cyc=%0d got=%b exp=%b", cyc, outs, O_NORM);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(3, 5, 3, 1, 0, 0, 0);
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rs cyc=%0d got=%b exp=%b", cyc, outs, O_LU);
    end
    set_in(3, 5, 3, 0, 0, 0, 0);
    checks++;
    if ({outs, stall_cnt} !== {O_NORM, (PERF ? CW'(1) : CW'(0))}) begin
      errors++; $display("FAIL load_use_release cyc=%0d got=%b exp=%b", cyc, {outs, stall_cnt}, {O_NORM, (PERF ? CW'(1) : CW'(0))});
    end
    set_in(1, 7, 7, 1, 0, 0, 0);
    checks++;
    if (outs !== O_LU) begin
      errors++; $display("FAIL load_use_rt cyc=%0d got=%b exp=%b", cyc, outs, O_LU);
    end
    set_in(0, 0, 0, 1, 0, 0, 0);
    checks++;
    if ({outs, stall_cnt} !== {O_NORM, (PERF ? CW'(2) : CW'(0))}) begin
      errors++; $display("FAIL load_r0 cyc=%0d got=%b exp=%b", cyc, {outs, stall_cnt}, {O_NORM, (PERF ? CW'(2) : CW'(0))});
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (outs !== O_FRZ) begin
        errors++; $display("FAIL mem_wait_frozen%0d cyc=%0d got=%b exp=%b", i, cyc, outs, O_FRZ);
      end
    end
    set_in(0, 0, 0, 0, 0, 1, 1);
    checks++;
    if ({outs, mem_timeout, stall_cnt} !== {O_NORM, 1'b0, (PERF ? CW'(3) : CW'(0))}) begin
      errors++; $display("FAIL mem_wait_ack cyc=%0d got=%b exp=%b", cyc, {outs, mem_timeout, stall_cnt}, {O_NORM, 1'b0, (PERF ? CW'(3) : CW'(0))});
    end
    set_in(0, 0, 0, 0, 0, 1, 1);
    checks++;
    if ({outs, stall_cnt} !== {O_NORM, (PERF ? CW'(3) : CW'(0))}) begin
      errors++; $display("FAIL zero_wait cyc=%0d got=%b exp=%b", cyc, {outs, stall_cnt}, {O_NORM, (PERF ? CW'(3) : CW'(0))});
    end
  endtask

  task automatic test_branch_freeze();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 0);
      checks++;
      if (outs !== O_FRZ) begin
        errors++; $display("FAIL branch_frozen%0d cyc=%0d got=%b exp=%b", i, cyc, outs, O_FRZ);
      end
    end
    set_in(0, 0, 0, 0, 1, 1, 1);
    checks++;
    if (outs !== O_BR) begin
      errors++; $display("FAIL branch_unfrozen cyc=%0d got=%b exp=%b", cyc, outs, O_BR);
    end
    set_in(3, 0, 3, 1, 1, 0, 0);
    checks++;
    if (outs !== O_BR) begin
      errors++; $display("FAIL branch_over_load_use cyc=%0d got=%b exp=%b", cyc, outs, O_BR);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < int'(TO); i++) begin
      set_in(0, 0, 0, 0, 0, 1, 0);
      checks++;
      if ({outs, mem_timeout} !== {O_FRZ, 1'b0}) begin
        errors++; $display("FAIL timeout_wait%0d cyc=%0d got=%b exp=%b", i, cyc, {outs, mem_timeout}, {O_FRZ, 1'b0});
      end
    end
    set_in(0, 0, 0, 0, 0, 1, 0);
    checks++;
    if ({outs, mem_timeout, stall_cnt} !== {O_FRZ, 1'b1, (PERF ? CW'(TO) : CW'(0))}) begin
      errors++; $display("FAIL timeout_err cyc=%0d got=%b exp=%b", cyc, {outs, mem_timeout, stall_cnt}, {O_FRZ, 1'b1, (PERF ? CW'(TO) : CW'(0))});
    end
    set_in(0, 0, 0, 0, 1, 0, 1);
    checks++;
    if ({outs, mem_timeout} !== {O_FRZ, 1'b1}) begin
      errors++; $display("FAIL timeout_hold cyc=%0d got=%b exp=%b", cyc, {outs, mem_timeout}, {O_FRZ, 1'b1});
    end
    repeat (16) set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({outs, stall_cnt} !== {O_FRZ, (PERF ? {CW{1'b1}} : CW'(0))}) begin
      errors++; $display("FAIL stall_saturate cyc=%0d got=%b exp=%b", cyc, {outs, stall_cnt}, {O_FRZ, (PERF ? {CW{1'b1}} : CW'(0))});
    end
  endtask

  task automatic test_reset_in_err();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({outs, mem_timeout, stall_cnt} !== {O_ZERO, 1'b0, CW'(0)}) begin
      errors++; $display("FAIL err_reset_async cyc=%0d got=%b exp=%b", cyc, {outs, mem_timeout, stall_cnt}, {O_ZERO, 1'b0, CW'(0)});
    end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++;
    if (outs !== O_ZERO) begin
      errors++; $display("FAIL err_reset_init cyc=%0d got=%b exp=%b", cyc, outs, O_ZERO);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({outs, mem_timeout} !== {O_NORM, 1'b0}) begin
      errors++; $display("FAIL err_reset_run cyc=%0d got=%b exp=%b", cyc, {outs, mem_timeout}, {O_NORM, 1'b0});
    end
  endtask

  task automatic test_random();
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_err && $urandom_range(0, 5) == 0) do_reset();
      set_in(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      e = exp_out();
      checks++;
      if ({outs, mem_timeout, stall_cnt} !== {e, m_err, (PERF ? m_stall : CW'(0))}) begin
        errors++; $display("FAIL random%0d cyc=%0d got=%b exp=%b", i, cyc, {outs, mem_timeout, stall_cnt}, {e, m_err, (PERF ? m_stall : CW'(0))});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_branch_freeze();
    test_timeout();
    test_reset_in_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
